// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl: game sequencer for lives, score, level, round timer and frog selection
module frogger_game_ctrl #(
  parameter int          NUM_FROGS    = 3,
  parameter int          LIVES_INIT   = 3,
  parameter int          ROUND_FRAMES = 1800,
  parameter int          DEATH_FRAMES = 60,
  parameter int          HOME_Y       = 40,
  parameter logic [15:0] KEY_START    = 16'h2C,
  parameter logic [15:0] KEY_FROG0    = 16'h59
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [15:0]            keycode,
  input  logic [NUM_FROGS*11-1:0] Frog_Y,
  input  logic                   hit,
  output logic                   game_reset,
  output logic                   freeze,
  output logic [NUM_FROGS-1:0]   frog_respawn,
  output logic [NUM_FROGS-1:0]   active_frog,
  output logic [NUM_FROGS-1:0]   frogs_home,
  output logic [2:0]             lives,
  output logic [9:0]             score,
  output logic [3:0]             level,
  output logic [10:0]            timer,
  output logic [2:0]             state
);
  typedef enum logic [2:0] {ATTRACT, START, PLAY, DYING, HOME, OVER} state_t;
  localparam int DW = $clog2(DEATH_FRAMES + 1);
  state_t                 st;
  logic                   fs1, fs2, fs3, tick, new_game, press, sel_ok, all_home;
  logic [15:0]            prev_key;
  logic [DW-1:0]          dcnt;
  logic [10:0]            act_y;
  logic [NUM_FROGS-1:0]   sel, home_next, not_home, low;
  logic [9:0]             sc50, sc150;
  assign state = st;
  function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [6:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {4'b0, b};
    return (s > 11'd999) ? 10'd999 : s[9:0];
  endfunction
  for (genvar i = 0; i < NUM_FROGS; i++) begin : g_sel
    assign sel[i] = keycode == 16'(KEY_FROG0 + i);
  end
  assign press     = keycode != 16'd0 && keycode != prev_key;
  assign sel_ok    = press && |(sel & ~frogs_home);
  assign home_next = frogs_home | active_frog;
  assign all_home  = &home_next;
  assign not_home  = ~home_next;
  assign low       = not_home & (-not_home);
  assign sc50      = sat_add(score, 7'd50);
  assign sc150     = sat_add(sc50, 7'd100);
  // Y position of whichever frog is currently active
  always_comb begin
    act_y = '0;
    for (int i = 0; i < NUM_FROGS; i++) act_y = active_frog[i] ? Frog_Y[11*i +: 11] : act_y;
  end
  // vsync synchroniser, rising-edge tick and previous keycode for press detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {fs1, fs2, fs3, tick} <= '0;
      prev_key <= '0;
    end else begin
      fs1 <= frame_clk;
      fs2 <= fs1;
      fs3 <= fs2;
      tick <= fs2 & ~fs3;
      prev_key <= keycode;
    end
  end
  // game sequencer with registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st <= ATTRACT;
      game_reset <= 1'b1;
      freeze <= 1'b1;
      frog_respawn <= '0;
      active_frog <= '0;
      frogs_home <= '0;
      lives <= '0;
      score <= '0;
      level <= '0;
      timer <= '0;
      new_game <= 1'b0;
      dcnt <= '0;
    end else begin
      frog_respawn <= '0;
      case (st)
        ATTRACT: begin
          game_reset <= 1'b1;
          freeze <= 1'b1;
          if (press && keycode == KEY_START) begin
            st <= START;
            new_game <= 1'b1;
          end
        end
        START: begin
          game_reset <= 1'b1;
          freeze <= 1'b1;
          if (new_game) begin
            lives <= 3'(LIVES_INIT);
            score <= '0;
            level <= '0;
          end
          frogs_home <= '0;
          active_frog <= NUM_FROGS'(1);
          timer <= 11'(ROUND_FRAMES);
          if (tick) begin
            st <= PLAY;
            game_reset <= 1'b0;
            freeze <= 1'b0;
          end
        end
        PLAY: begin
          game_reset <= 1'b0;
          freeze <= 1'b0;
          if (sel_ok) active_frog <= sel;
          if (tick) begin
            if (hit || (act_y > 11'(HOME_Y) && timer == 11'd0)) begin
              st <= DYING;
              freeze <= 1'b1;
              dcnt <= '0;
            end else if (act_y <= 11'(HOME_Y)) st <= HOME;
            else timer <= timer - 11'd1;
          end
        end
        DYING: begin
          freeze <= 1'b1;
          if (tick) begin
            if (dcnt == DW'(DEATH_FRAMES - 1)) begin
              lives <= lives - 3'd1;
              if (lives == 3'd1) st <= OVER;
              else begin
                frog_respawn <= active_frog;
                timer <= 11'(ROUND_FRAMES);
                st <= PLAY;
                freeze <= 1'b0;
              end
            end else dcnt <= dcnt + DW'(1);
          end
        end
        HOME: begin
          score <= all_home ? sc150 : sc50;
          frogs_home <= all_home ? '0 : home_next;
          if (all_home) begin
            level <= level + {3'b0, level != 4'd15};
            new_game <= 1'b0;
            game_reset <= 1'b1;
            freeze <= 1'b1;
            st <= START;
          end else begin
            active_frog <= low;
            frog_respawn <= low;
            timer <= 11'(ROUND_FRAMES);
            st <= PLAY;
          end
        end
        OVER: begin
          freeze <= 1'b1;
          game_reset <= 1'b0;
          if (press && keycode == KEY_START) begin
            st <= START;
            new_game <= 1'b1;
          end
        end
        default: begin
          st <= ATTRACT;
          game_reset <= 1'b1;
          freeze <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frogger_game_ctrl.sv
// tb_frogger_game_ctrl: directed scenario bench for the game sequencer
module tb_frogger_game_ctrl;
  logic        Clk = 0, Reset_n = 0, frame_clk = 0, hit = 0;
  logic [15:0] keycode = 0;
  logic [32:0] Frog_Y = {3{11'd200}};
  logic        game_reset, freeze;
  logic [2:0]  frog_respawn, active_frog, frogs_home, lives, state;
  logic [9:0]  score;
  logic [3:0]  level;
  logic [10:0] timer;
  int vectors = 0, miscompares = 0;

  frogger_game_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .Frog_Y(Frog_Y), .hit(hit), .game_reset(game_reset), .freeze(freeze),
    .frog_respawn(frog_respawn), .active_frog(active_frog), .frogs_home(frogs_home),
    .lives(lives), .score(score), .level(level), .timer(timer), .state(state)
  );

  always #5 Clk = ~Clk;

  task automatic tick_rise;
    @(negedge Clk);
    frame_clk = 1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic tick_fall;
    frame_clk = 0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic tick;
    tick_rise();
    tick_fall();
  endtask

  task automatic press_key(input logic [15:0] k);
    @(negedge Clk);
    keycode = k;
    @(negedge Clk);
    keycode = 0;
  endtask

  task automatic go_home(input int f);
    Frog_Y[11*f +: 11] = 11'd30;
    tick_rise();
    @(negedge Clk);
    Frog_Y[11*f +: 11] = 11'd200;
    tick_fall();
  endtask

  task automatic kill(input logic [2:0] exp_lives, input logic [2:0] exp_resp, input bit to_over);
    hit = 1;
    tick();
    hit = 0;
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL die_state: got %0d expected 3", state); end
    vectors++; if (freeze !== 1'b1) begin miscompares++; $display("FAIL die_freeze: got %0b expected 1", freeze); end
    repeat (59) tick();
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL die_59_still: got %0d expected 3", state); end
    tick_rise();
    vectors++; if (lives !== exp_lives) begin miscompares++; $display("FAIL die_lives: got %0d expected %0d", lives, exp_lives); end
    if (to_over) begin
      vectors++; if (state !== 3'd5) begin miscompares++; $display("FAIL die_over: got %0d expected 5", state); end
      vectors++; if (frog_respawn !== 3'b000) begin miscompares++; $display("FAIL die_over_resp: got %b expected 000", frog_respawn); end
    end else begin
      vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL die_back_play: got %0d expected 2", state); end
      vectors++; if (frog_respawn !== exp_resp) begin miscompares++; $display("FAIL die_resp: got %b expected %b", frog_respawn, exp_resp); end
      vectors++; if (timer !== 11'd1800) begin miscompares++; $display("FAIL die_timer: got %0d expected 1800", timer); end
      @(negedge Clk);
      vectors++; if (frog_respawn !== 3'b000) begin miscompares++; $display("FAIL die_resp_pulse: got %b expected 000", frog_respawn); end
    end
    tick_fall();
  endtask

  task automatic test_reset;
    #12;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state); end
    vectors++; if ({game_reset, freeze} !== 2'b11) begin miscompares++; $display("FAIL rst_flags: got %b expected 11", {game_reset, freeze}); end
    vectors++; if ({frog_respawn, active_frog, frogs_home} !== 9'd0) begin miscompares++; $display("FAIL rst_frogs: got %b expected 0", {frog_respawn, active_frog, frogs_home}); end
    vectors++; if ({lives, score, level, timer} !== 28'd0) begin miscompares++; $display("FAIL rst_counts: got %h expected 0", {lives, score, level, timer}); end
    @(negedge Clk);
    Reset_n = 1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_start;
    press_key(16'h2C);
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL start_state: got %0d expected 1", state); end
    vectors++; if (game_reset !== 1'b1) begin miscompares++; $display("FAIL start_greset: got %0b expected 1", game_reset); end
    tick();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL play_state: got %0d expected 2", state); end
    vectors++; if (lives !== 3'd3) begin miscompares++; $display("FAIL play_lives: got %0d expected 3", lives); end
    vectors++; if (timer !== 11'd1800) begin miscompares++; $display("FAIL play_timer: got %0d expected 1800", timer); end
    vectors++; if (active_frog !== 3'b001) begin miscompares++; $display("FAIL play_active: got %b expected 001", active_frog); end
    vectors++; if ({game_reset, freeze} !== 2'b00) begin miscompares++; $display("FAIL play_flags: got %b expected 00", {game_reset, freeze}); end
  endtask

  task automatic test_hold_key;
    @(negedge Clk);
    keycode = 16'h04;
    repeat (10) tick();
    keycode = 0;
    vectors++; if (timer !== 11'd1790) begin miscompares++; $display("FAIL hold_timer: got %0d expected 1790", timer); end
    vectors++; if (active_frog !== 3'b001) begin miscompares++; $display("FAIL hold_active: got %b expected 001", active_frog); end
  endtask

  task automatic test_death;
    kill(3'd2, 3'b001, 1'b0);
  endtask

  task automatic test_home_priority;
    Frog_Y[10:0] = 11'd30;
    kill(3'd1, 3'b001, 1'b0);
    tick_rise();
    vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL home_state: got %0d expected 4", state); end
    @(negedge Clk);
    Frog_Y[10:0] = 11'd200;
    vectors++; if (score !== 10'd50) begin miscompares++; $display("FAIL home_score: got %0d expected 50", score); end
    vectors++; if (frogs_home !== 3'b001) begin miscompares++; $display("FAIL home_mask: got %b expected 001", frogs_home); end
    vectors++; if (active_frog !== 3'b010) begin miscompares++; $display("FAIL home_next: got %b expected 010", active_frog); end
    vectors++; if (frog_respawn !== 3'b010) begin miscompares++; $display("FAIL home_resp: got %b expected 010", frog_respawn); end
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL home_play: got %0d expected 2", state); end
    tick_fall();
    press_key(16'h59);
    vectors++; if (active_frog !== 3'b010) begin miscompares++; $display("FAIL sel_home_ignored: got %b expected 010", active_frog); end
    press_key(16'h5B);
    vectors++; if (active_frog !== 3'b100) begin miscompares++; $display("FAIL sel_frog2: got %b expected 100", active_frog); end
    press_key(16'h5A);
    vectors++; if (active_frog !== 3'b010) begin miscompares++; $display("FAIL sel_frog1: got %b expected 010", active_frog); end
  endtask

  task automatic test_level_clear;
    go_home(1);
    vectors++; if ({score, frogs_home, active_frog} !== {10'd100, 3'b011, 3'b100}) begin miscompares++; $display("FAIL home2: got score %0d home %b act %b expected 100 011 100", score, frogs_home, active_frog); end
    go_home(2);
    vectors++; if (score !== 10'd250) begin miscompares++; $display("FAIL lvl_score: got %0d expected 250", score); end
    vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL lvl_level: got %0d expected 1", level); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL lvl_start: got %0d expected 1", state); end
    vectors++; if (frogs_home !== 3'b000) begin miscompares++; $display("FAIL lvl_mask: got %b expected 000", frogs_home); end
    vectors++; if (lives !== 3'd1) begin miscompares++; $display("FAIL lvl_lives: got %0d expected 1", lives); end
    tick();
    vectors++; if ({state, lives, active_frog} !== {3'd2, 3'd1, 3'b001}) begin miscompares++; $display("FAIL lvl_replay: got %0d %0d %b expected 2 1 001", state, lives, active_frog); end
  endtask

  task automatic test_game_over;
    kill(3'd0, 3'b000, 1'b1);
    vectors++; if ({score, level, freeze} !== {10'd250, 4'd1, 1'b1}) begin miscompares++; $display("FAIL over_hold: got %0d %0d %b expected 250 1 1", score, level, freeze); end
  endtask

  task automatic test_saturate;
    int exp_score;
    exp_score = 0;
    press_key(16'h2C);
    tick();
    vectors++; if ({state, score, level, lives} !== {3'd2, 10'd0, 4'd0, 3'd3}) begin miscompares++; $display("FAIL newgame: got %0d %0d %0d %0d expected 2 0 0 3", state, score, level, lives); end
    for (int l = 1; l <= 4; l++) begin
      for (int f = 0; f < 3; f++) go_home(f);
      exp_score = (exp_score + 250 > 999) ? 999 : exp_score + 250;
      vectors++; if (score !== 10'(exp_score)) begin miscompares++; $display("FAIL sat_score_l%0d: got %0d expected %0d", l, score, exp_score); end
      vectors++; if (level !== 4'(l)) begin miscompares++; $display("FAIL sat_level: got %0d expected %0d", level, l); end
      tick();
    end
    go_home(0);
    vectors++; if (score !== 10'd999) begin miscompares++; $display("FAIL sat_hold: got %0d expected 999", score); end
  endtask

  task automatic test_timeout;
    repeat (1800) tick();
    vectors++; if ({state, timer} !== {3'd2, 11'd0}) begin miscompares++; $display("FAIL tmo_zero: got %0d %0d expected 2 0", state, timer); end
    tick();
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL tmo_die: got %0d expected 3", state); end
  endtask

  task automatic test_reset_mid;
    repeat (5) tick();
    @(negedge Clk);
    Reset_n = 0;
    #1;
    vectors++; if ({state, game_reset, freeze} !== {3'd0, 2'b11}) begin miscompares++; $display("FAIL mid_rst_state: got %0d %b expected 0 11", state, {game_reset, freeze}); end
    vectors++; if ({frog_respawn, active_frog, frogs_home, lives, score, level, timer} !== 37'd0) begin miscompares++; $display("FAIL mid_rst_vals: got %h expected 0", {frog_respawn, active_frog, frogs_home, lives, score, level, timer}); end
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    tick();
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL mid_rst_attract: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hold_key();
    test_death();
    test_home_priority();
    test_level_clear();
    test_game_over();
    test_saturate();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
